rgb_fade_ctrl: RTL

Fade controller for the RGB mixer: accepts a colour command (R/G/B target levels plus ramp rate) over a valid/ready handshake and steps each channel's 8-bit PWM level toward its target by one LSB per ramp step. Level changes occur only on PWM frame boundaries, so no PWM period sees a mid-period duty change. Sits between the command source (encoders/host) and the three `pwm` instances, driving their `level` inputs directly.

---
 rtl/rgb_mixer_pkg.sv | 14 +
 rtl/fade_step.sv | 46 ++++
 rtl/rgb_fade_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rgb_mixer_pkg.sv
// Shared types and constants for the RGB mixer fade path.
package rgb_mixer_pkg;

  localparam int LEVEL_W = 8;
  localparam int NUM_CH  = 3;
  localparam logic [LEVEL_W-1:0] FRAME_MAX = {LEVEL_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } fade_state_e;

endpackage

// File: rtl/fade_step.sv
// One channel's level register; steps one LSB toward target when step_en is high.
module fade_step
  import rgb_mixer_pkg::*;
#(
  parameter int W = LEVEL_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         step_en,
  input  logic [W-1:0] target,
  output logic [W-1:0] level,
  output logic         at_target,
  output logic         next_at_target
);

  logic [W-1:0] r_level;
  logic [W-1:0] w_next;

  // Next level one LSB toward target; never overshoots, so no wrap is possible.
  always_comb begin
    w_next = r_level;
    if (r_level < target) begin
      w_next = r_level + W'(1);
    end else if (r_level > target) begin
      w_next = r_level - W'(1);
    end else begin
      w_next = r_level;
    end
  end

  // Level register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= '0;
    end else if (step_en) begin
      r_level <= w_next;
    end else begin
      r_level <= r_level;
    end
  end

  assign level          = r_level;
  assign at_target      = (r_level == target);
  assign next_at_target = (w_next == target);

endmodule

// File: rtl/rgb_fade_ctrl.sv
// Fade controller: accepts an RGB target plus ramp rate and walks the three
// PWM levels toward it, changing levels only on PWM frame boundaries.
module rgb_fade_ctrl
  import rgb_mixer_pkg::*;
#(
  parameter int WIDTH  = LEVEL_W,
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_r,
  input  logic [WIDTH-1:0]  cmd_g,
  input  logic [WIDTH-1:0]  cmd_b,
  input  logic [RATE_W-1:0] cmd_rate,
  input  logic              abort,
  output logic [WIDTH-1:0]  level_r,
  output logic [WIDTH-1:0]  level_g,
  output logic [WIDTH-1:0]  level_b,
  output logic              frame_tick,
  output logic              busy,
  output logic              done
);

  // Tick is registered, so it is raised one count early to line up with count FRAME_MAX.
  localparam logic [WIDTH-1:0] TICK_PRE = WIDTH'(FRAME_MAX) - WIDTH'(1);

  fade_state_e                  r_state;
  fade_state_e                  w_state_nxt;
  logic [WIDTH-1:0]             r_frame_cnt;
  logic                         r_frame_tick;
  logic [NUM_CH-1:0][WIDTH-1:0] r_tgt;
  logic [NUM_CH-1:0][WIDTH-1:0] w_cmd_tgt;
  logic [NUM_CH-1:0][WIDTH-1:0] w_level;
  logic [NUM_CH-1:0]            w_at;
  logic [NUM_CH-1:0]            w_near;
  logic [RATE_W-1:0]            r_rate;
  logic [RATE_W-1:0]            r_rate_cnt;
  logic [RATE_W-1:0]            w_rate_cnt_nxt;
  logic                         w_accept;
  logic                         w_step_en;
  logic                         w_cmd_eq;
  logic                         r_cmd_ready;
  logic                         r_busy;
  logic                         r_done;

  assign w_cmd_tgt = {cmd_b, cmd_g, cmd_r};
  assign w_cmd_eq  = (w_cmd_tgt == w_level);

  // Free-running frame counter, aligned with the pwm counters out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt  <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_cnt  <= r_frame_cnt + WIDTH'(1);
      r_frame_tick <= (r_frame_cnt == TICK_PRE);
    end
  end

  // Next-state, step enable and rate counter update.
  always_comb begin
    w_state_nxt    = r_state;
    w_step_en      = 1'b0;
    w_accept       = 1'b0;
    w_rate_cnt_nxt = r_rate_cnt;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_accept       = 1'b1;
          w_rate_cnt_nxt = cmd_rate;
          w_state_nxt    = w_cmd_eq ? ST_DONE : ST_RAMP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RAMP: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (&w_at) begin
          w_state_nxt = ST_DONE;
        end else if (r_frame_tick) begin
          if (r_rate_cnt != '0) begin
            w_rate_cnt_nxt = r_rate_cnt - RATE_W'(1);
          end else begin
            w_step_en      = 1'b1;
            w_rate_cnt_nxt = r_rate;
            w_state_nxt    = (&w_near) ? ST_DONE : ST_RAMP;
          end
        end else begin
          w_state_nxt = ST_RAMP;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, latched command and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_tgt       <= '0;
      r_rate      <= '0;
      r_rate_cnt  <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rate_cnt  <= w_rate_cnt_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt == ST_RAMP) || (w_state_nxt == ST_DONE);
      r_done      <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_tgt  <= w_cmd_tgt;
        r_rate <= cmd_rate;
      end else begin
        r_tgt  <= r_tgt;
        r_rate <= r_rate;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    fade_step #(.W(WIDTH)) u_step (
      .clk            (clk),
      .reset_n        (reset_n),
      .step_en        (w_step_en),
      .target         (r_tgt[gi]),
      .level          (w_level[gi]),
      .at_target      (w_at[gi]),
      .next_at_target (w_near[gi])
    );
  end

  assign level_r    = w_level[0];
  assign level_g    = w_level[1];
  assign level_b    = w_level[2];
  assign frame_tick = r_frame_tick;
  assign cmd_ready  = r_cmd_ready;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
